// File: rtl/edge_event_arbiter.sv
// -----------------------------------------------------------------------------
// edge_event_arbiter
//
// Purpose:
//   Shares one event output stream between CH_NUM asynchronous input lines.
//   Each line is synchronised, edge-detected according to its own mode and
//   latched as a pending event. A round-robin arbiter serialises the pending
//   events onto a single valid/ready stream carrying channel index and edge
//   polarity.
//
// Ports:
//   sys_clk    in   clock
//   sys_rst_n  in   asynchronous active-low reset
//   sig_in     in   [CH_NUM]    raw asynchronous input lines
//   edge_mode  in   [2*CH_NUM]  per channel {fall_en, rise_en}: 00 off,
//                               01 rising, 10 falling, 11 both
//   evt_valid  out  event available on evt_ch / evt_rise
//   evt_ready  in   consumer accepts the event when high with evt_valid
//   evt_ch     out  [IDX_W]     channel index of the presented event
//   evt_rise   out  1 = rising edge, 0 = falling edge
//   ovf        out  [CH_NUM]    sticky per-channel overflow flags
//   ovf_clr    in   [CH_NUM]    per-channel synchronous clear of ovf
// -----------------------------------------------------------------------------
module edge_event_arbiter #(
  parameter int CH_NUM = 4,
  parameter int IDX_W  = 2
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [CH_NUM-1:0]   sig_in,
  input  logic [2*CH_NUM-1:0] edge_mode,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [IDX_W-1:0]    evt_ch,
  output logic                evt_rise,
  output logic [CH_NUM-1:0]   ovf,
  input  logic [CH_NUM-1:0]   ovf_clr
);

  // ---------------------------------------------------------------------------
  // Control FSM: WARMUP holds edge detection off for the first three clocks
  // after reset release, while the synchroniser and delay flops fill with the
  // real line levels. A line held high through reset therefore never looks
  // like a rising edge.
  // ---------------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } state_e;

  state_e     state_q;
  logic [1:0] warm_cnt_q;
  logic       det_en_q;   // registered FSM output: edge detection enabled

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_WARMUP;
      warm_cnt_q <= 2'd0;
      det_en_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_WARMUP: begin
          // Third clock after release: detection becomes active from the
          // following cycle onward.
          if (warm_cnt_q == 2'd2) begin
            state_q  <= ST_RUN;
            det_en_q <= 1'b1;
          end else begin
            warm_cnt_q <= warm_cnt_q + 2'd1;
          end
        end
        ST_RUN: begin
          det_en_q <= 1'b1;
        end
        default: begin
          state_q  <= ST_WARMUP;
          det_en_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Synchroniser (s0, s1) and delay flop (d) for every channel.
  // ---------------------------------------------------------------------------
  logic [CH_NUM-1:0] s0_q;
  logic [CH_NUM-1:0] s1_q;
  logic [CH_NUM-1:0] d_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s0_q <= '0;
      s1_q <= '0;
      d_q  <= '0;
    end else begin
      s0_q <= sig_in;
      s1_q <= s0_q;
      d_q  <= s1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending state, overflow flags, output register and round-robin pointer.
  // ---------------------------------------------------------------------------
  logic [CH_NUM-1:0] pend_q;
  logic [CH_NUM-1:0] pend_d;
  logic [CH_NUM-1:0] pend_rise_q;
  logic [CH_NUM-1:0] pend_rise_d;
  logic [CH_NUM-1:0] ovf_q;
  logic [CH_NUM-1:0] ovf_d;

  logic              evt_valid_q;
  logic              evt_valid_d;
  logic [IDX_W-1:0]  evt_ch_q;
  logic [IDX_W-1:0]  evt_ch_d;
  logic              evt_rise_q;
  logic              evt_rise_d;
  logic [IDX_W-1:0]  ptr_q;
  logic [IDX_W-1:0]  ptr_d;

  logic [CH_NUM-1:0] rise_det;
  logic [CH_NUM-1:0] fall_det;
  logic [CH_NUM-1:0] edge_hit;
  logic [CH_NUM-1:0] grant_ch;
  logic [CH_NUM-1:0] ovf_set;

  logic              load;
  logic [IDX_W-1:0]  win_idx;
  logic [IDX_W-1:0]  hi_idx;
  logic              hi_found;
  logic [IDX_W-1:0]  lo_idx;

  // ---------------------------------------------------------------------------
  // Round-robin winner: the lowest pending channel above ptr if any exists,
  // otherwise the lowest pending channel overall (the wrap back to 0).
  // Scanning downward lets the last match be the lowest index.
  // ---------------------------------------------------------------------------
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        lo_idx = IDX_W'(i);
        if (i > int'(ptr_q)) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(i);
        end
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;
  end

  // The output register is free when empty or being accepted this cycle.
  assign load = (~evt_valid_q | evt_ready) & (|pend_q);

  // ---------------------------------------------------------------------------
  // Per-channel edge qualification and pending / overflow next state.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
    localparam logic [IDX_W-1:0] CH_IDX = IDX_W'(gi);

    assign rise_det[gi] = det_en_q & edge_mode[2*gi]   &  s1_q[gi] & ~d_q[gi];
    assign fall_det[gi] = det_en_q & edge_mode[2*gi+1] & ~s1_q[gi] &  d_q[gi];
    assign edge_hit[gi] = rise_det[gi] | fall_det[gi];

    assign grant_ch[gi] = load & (win_idx == CH_IDX);

    // A new edge always leaves the channel pending with the newest type,
    // even when the old event is being granted in the same cycle.
    assign pend_d[gi]      = edge_hit[gi] | (pend_q[gi] & ~grant_ch[gi]);
    assign pend_rise_d[gi] = edge_hit[gi] ? rise_det[gi] : pend_rise_q[gi];

    // Overwriting a pending event that is not leaving this cycle loses it.
    assign ovf_set[gi] = edge_hit[gi] & pend_q[gi] & ~grant_ch[gi];
    // Set dominates clear.
    assign ovf_d[gi]   = ovf_set[gi] | (ovf_q[gi] & ~ovf_clr[gi]);
  end

  // ---------------------------------------------------------------------------
  // Output register next state. Event fields only change on a load, so they
  // stay stable while the consumer stalls.
  // ---------------------------------------------------------------------------
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_ch_d    = evt_ch_q;
    evt_rise_d  = evt_rise_q;
    ptr_d       = ptr_q;
    if (load) begin
      evt_valid_d = 1'b1;
      evt_ch_d    = win_idx;
      evt_rise_d  = pend_rise_q[win_idx];
      ptr_d       = win_idx;
    end else if (evt_ready) begin
      evt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pend_q      <= '0;
      pend_rise_q <= '0;
      ovf_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      evt_rise_q  <= 1'b0;
      // Starting at the top channel makes channel 0 the first priority.
      ptr_q       <= IDX_W'(CH_NUM - 1);
    end else begin
      pend_q      <= pend_d;
      pend_rise_q <= pend_rise_d;
      ovf_q       <= ovf_d;
      evt_valid_q <= evt_valid_d;
      evt_ch_q    <= evt_ch_d;
      evt_rise_q  <= evt_rise_d;
      ptr_q       <= ptr_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_ch    = evt_ch_q;
  assign evt_rise  = evt_rise_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// -----------------------------------------------------------------------------
// tb_edge_event_arbiter
//
// Scoreboard bench for edge_event_arbiter. A reference model driven by the
// sampled inputs predicts each presented event and pushes it into a queue;
// a monitor on the falling edge compares the DUT's presented event against
// the queue head and pops it on every accepted handshake. Valid and overflow
// flags are compared against the model every cycle.
// -----------------------------------------------------------------------------
module tb_edge_event_arbiter;

  localparam int CH = 4;
  localparam int IW = 2;

  logic            sys_clk   = 1'b0;
  logic            sys_rst_n = 1'b0;
  logic [CH-1:0]   sig_in    = '0;
  logic [2*CH-1:0] edge_mode = '0;
  logic            evt_ready = 1'b0;
  logic [CH-1:0]   ovf_clr   = '0;
  logic            evt_valid;
  logic [IW-1:0]   evt_ch;
  logic            evt_rise;
  logic [CH-1:0]   ovf;

  always #5 sys_clk = ~sys_clk;

  edge_event_arbiter #(.CH_NUM(CH), .IDX_W(IW)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .sig_in    (sig_in),
    .edge_mode (edge_mode),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_rise  (evt_rise),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. Time is counted in clocks since reset release; the
  // sample taken at clock j is samp_q[j-1]. An input change between the
  // samples of clocks j-1 and j becomes pending at clock j+2, and no edge is
  // recognised before clock 4.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [IW-1:0] ch;
    logic          rise;
  } evt_t;

  evt_t          exp_q[$];
  logic [CH-1:0] samp_q[$];
  logic [CH-1:0] m_pend  = '0;
  logic [CH-1:0] m_prise = '0;
  logic [CH-1:0] m_ovf   = '0;
  logic          m_valid = 1'b0;
  int            m_ptr   = CH - 1;

  function automatic logic [CH-1:0] samp_at(input int j);
    if (j < 1 || j > samp_q.size()) return '0;
    return samp_q[j-1];
  endfunction

  initial begin
    forever begin
      @(posedge sys_clk or negedge sys_rst_n);
      if (!sys_rst_n) begin
        samp_q.delete();
        exp_q.delete();
        m_pend  = '0;
        m_prise = '0;
        m_ovf   = '0;
        m_valid = 1'b0;
        m_ptr   = CH - 1;
      end else begin
        int            n;
        int            win;
        logic          wrise;
        logic [CH-1:0] sa;
        logic [CH-1:0] sb;
        logic [CH-1:0] oset;
        evt_t          e;
        samp_q.push_back(sig_in);
        n  = samp_q.size();
        sa = samp_at(n - 3);
        sb = samp_at(n - 2);
        // Pick the next pending channel after the last one served.
        win = -1;
        if (!m_valid || evt_ready) begin
          for (int k = 1; k <= CH; k++) begin
            int c;
            c = (m_ptr + k) % CH;
            if (win < 0 && m_pend[c]) win = c;
          end
        end
        wrise = (win >= 0) ? m_prise[win] : 1'b0;
        oset  = '0;
        for (int c = 0; c < CH; c++) begin
          logic r;
          logic f;
          r = (n >= 4) && edge_mode[2*c]   && !sa[c] &&  sb[c];
          f = (n >= 4) && edge_mode[2*c+1] &&  sa[c] && !sb[c];
          if (r || f) begin
            if (m_pend[c] && c != win) oset[c] = 1'b1;
            m_pend[c]  = 1'b1;
            m_prise[c] = r;
          end else if (c == win) begin
            m_pend[c] = 1'b0;
          end
        end
        m_ovf = (m_ovf & ~ovf_clr) | oset;
        if (win >= 0) begin
          e.ch   = IW'(win);
          e.rise = wrise;
          exp_q.push_back(e);
          m_valid = 1'b1;
          m_ptr   = win;
        end else if (evt_ready) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: compares on the falling edge, away from the active edge.
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge sys_clk);
      chk("evt_valid", 32'(evt_valid), 32'(m_valid));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      if (evt_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", 32'(1), 32'(0));
        end else begin
          chk("evt_ch", 32'(evt_ch), 32'(exp_q[0].ch));
          chk("evt_rise", 32'(evt_rise), 32'(exp_q[0].rise));
          if (evt_ready) begin
            $display("evt accepted ch=%0d rise=%0d @%0t", evt_ch, evt_rise, $time);
            void'(exp_q.pop_front());
            n_acc++;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus: inputs change 1 time unit after the active edge.
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  initial begin
    // Line held high through reset release with all modes on: no event.
    sys_rst_n = 1'b0;
    sig_in    = 4'b0010;
    edge_mode = 8'hFF;
    evt_ready = 1'b1;
    step(3);
    sys_rst_n = 1'b1;
    step(30);
    chk("no_event_after_warmup", 32'(n_acc), 32'(0));

    // Channel 2 rising only: rise reported, fall ignored.
    edge_mode = 8'h10;
    sig_in    = 4'b0000;
    step(6);
    sig_in = 4'b0100;
    step(8);
    sig_in = 4'b0000;
    step(8);

    // All channels both edges, simultaneous rise then fall.
    edge_mode = 8'hFF;
    sig_in    = 4'b1111;
    step(10);
    sig_in = 4'b0000;
    step(10);

    // Overflow on channel 1 while the output is occupied by channel 0.
    evt_ready = 1'b0;
    sig_in    = 4'b0001;
    step(4);
    sig_in = 4'b0011;
    step(4);
    sig_in = 4'b0001;
    step(6);
    evt_ready = 1'b1;
    step(8);
    ovf_clr = 4'b0010;
    step(1);
    ovf_clr = 4'b0000;
    step(3);

    // Backpressure with channels 0 and 3 pending.
    sig_in = 4'b0000;
    step(8);
    evt_ready = 1'b0;
    sig_in    = 4'b1001;
    step(14);
    evt_ready = 1'b1;
    step(8);

    // Reset while an event is presented and others are pending.
    evt_ready = 1'b0;
    sig_in    = 4'b0110;
    step(6);
    sys_rst_n = 1'b0;
    step(2);
    sys_rst_n = 1'b1;
    step(12);

    // Randomised traffic.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(3) == 0) sig_in[$urandom_range(CH-1)] = ~sig_in[$urandom_range(CH-1)];
      if ($urandom_range(3) == 0) sig_in = sig_in ^ CH'($urandom_range(15));
      evt_ready = ($urandom_range(3) != 0);
      if ($urandom_range(63) == 0) edge_mode = 8'($urandom);
      ovf_clr = ($urandom_range(15) == 0) ? CH'($urandom) : '0;
      if ($urandom_range(799) == 0) begin
        sys_rst_n = 1'b0;
        step(2);
        sys_rst_n = 1'b1;
      end
      step(1);
    end

    // Drain.
    evt_ready = 1'b1;
    ovf_clr   = '0;
    step(20);
    chk("drain_empty", 32'(exp_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/edge_event_arbiter.md
# edge_event_arbiter

Multi-channel edge-event scheduler that shares a single event output port between CH_NUM asynchronous input lines. Each line is synchronised, edge-detected per a per-channel mode, and latched as a pending event. A round-robin arbiter then serialises pending events onto one valid/ready stream (channel index + edge polarity) for a downstream consumer such as an interrupt controller or event FIFO. It sits between raw pins/key inputs and the control logic that consumes edge pulses.

## Interface
- CH_NUM, 4, number of input channels (2..16)
- IDX_W, 2, width of channel index; must satisfy 2**IDX_W >= CH_NUM
- sys_clk  in  1  clock
- sys_rst_n  in  1  reset sys_rst_n, asynchronous, active-low; clock sys_clk
- sig_in  in  CH_NUM  raw asynchronous input lines
- edge_mode  in  2*CH_NUM  per channel bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
- evt_valid  out  1  event available on evt_ch/evt_rise
- evt_ready  in  1  consumer accepts event when high with evt_valid
- evt_ch  out  IDX_W  channel index of presented event
- evt_rise  out  1  1 = rising edge, 0 = falling edge
- ovf  out  CH_NUM  sticky per-channel overflow flags
- ovf_clr  in  CH_NUM  per-channel synchronous clear of ovf

## Operation
- Per channel: two-flop synchroniser (s0, s1) then delay flop d; rise = s1 & ~d, fall = ~s1 & d; qualified by edge_mode.
- Control FSM: WARMUP -> RUN. WARMUP lasts 3 cycles after reset release; edge detection suppressed (sync/delay flops still load) so a line held high through reset produces no event. RUN is permanent until reset.
- Pending: per-channel pend bit + pend_rise bit. Qualified edge sets pend=1 and pend_rise to the edge type.
- Overflow: qualified edge on a channel whose pend=1 and which is not being granted this cycle -> ovf[i] set, pend_rise overwritten with newest type (newest wins, one event retained).
- Grant: output register loads when (!evt_valid || evt_ready) and any pend=1. Winner = first pending channel searching upward from ptr+1 with wrap at CH_NUM-1 -> 0. Same clock: pend[winner] cleared, evt_ch/evt_rise loaded, evt_valid=1, ptr=winner.
- Grant with simultaneous new edge on winner: pend stays 1 with new type; no overflow.
- No pending and evt_ready accepted: evt_valid -> 0.
- evt_ch/evt_rise stable while evt_valid=1 and evt_ready=0.
- ovf_clr[i] clears ovf[i]; set wins over clear in the same cycle.
- edge_mode change does not clear existing pend bits; mode 00 only blocks new detection.

## Timing
- Reset values: evt_valid 0, evt_ch 0, evt_rise 0, ovf 0, all pend 0, sync/delay flops 0, ptr CH_NUM-1 (channel 0 first priority), FSM WARMUP.
- Latency: sig_in transition sampled at clock k -> pend set at clock k+2 -> evt_valid high after clock k+3 (3 cycles) when output register free.
- Throughput: one event per cycle with evt_ready held high.
- Inputs must hold ≥2 sys_clk periods to be reliably captured; shorter pulses may be lost.
- Reset asserted mid-operation: all pending events and ovf discarded immediately; WARMUP re-entered on release.

## Test plan
- Reset, sig_in=4'b0010 held through release, mode all 11 -> no event ever; evt_valid stays 0.
- Ch2 mode 01, sig_in[2] 0->1 at clock k, evt_ready=1 -> evt_valid=1 after k+3 for one cycle, evt_ch=2, evt_rise=1; falling edge produces nothing.
- All four channels mode 11, simultaneous rise, evt_ready=1 -> four consecutive events ch 0,1,2,3; second simultaneous fall -> order 0,1,2,3 again (ptr wrapped from 3).
- evt_ready=0, ch1 rise then fall 4 cycles later -> ovf[1]=1, single presented/pending event with evt_rise=0 after ready; ovf_clr[1] pulse -> ovf[1]=0.
- Backpressure: evt_ready low 10 cycles with ch0 and ch3 pending -> evt_ch/evt_rise constant while stalled; ch3 presented immediately after ch0 accept.
- Reset pulsed while evt_valid=1 and two channels pending -> outputs return to reset values, no stale events after release.
